rc4_prga_engine: RTL and testbench

- Parametrised RC4 keystream/decrypt engine: the next generation of the fixed-length decrypt task. Combines the FSM and datapath in one block.
- Runs after S-box initialisation and key scheduling have filled s_mem. Reads a length-prefixed ciphertext from enc_mem, runs the RC4 PRGA swap sequence on s_mem, and writes a length-prefixed plaintext to dec_mem.
- Adds runtime message length, length clipping, wider message address space and an optional plaintext validity abort for key-search use.

---
 rtl/rc4_prga_engine_if.sv | 31 +++
 rtl/rc4_prga_engine.sv | 162 ++++++++++++++++
 tb/tb_rc4_prga_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_prga_engine_if.sv
// Handshake and memory-port bundle between rc4_prga_engine and its s/enc/dec memories.
interface rc4_prga_engine_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        data_from_s_mem;
  logic [7:0]        data_from_enc_mem;
  logic              wr_en;
  logic              wr_en_dec;
  logic              task_on;
  logic              fin_strobe;
  logic [7:0]        addr_to_s_mem;
  logic [7:0]        data_to_s_mem;
  logic [ADDR_W-1:0] addr_to_enc_mem;
  logic [ADDR_W-1:0] addr_to_dec_mem;
  logic [7:0]        data_to_dec_mem;
  logic              len_clipped;
  logic              invalid;

  modport master (
    input  start, data_from_s_mem, data_from_enc_mem,
    output wr_en, wr_en_dec, task_on, fin_strobe, addr_to_s_mem, data_to_s_mem,
           addr_to_enc_mem, addr_to_dec_mem, data_to_dec_mem, len_clipped, invalid
  );

  modport slave (
    output start, data_from_s_mem, data_from_enc_mem,
    input  wr_en, wr_en_dec, task_on, fin_strobe, addr_to_s_mem, data_to_s_mem,
           addr_to_enc_mem, addr_to_dec_mem, data_to_dec_mem, len_clipped, invalid
  );
endinterface

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA decrypt engine: length-prefixed ciphertext in enc_mem -> plaintext in dec_mem.
// Optional macro RC4_TEXT_CHECK_EN aborts on the first byte that is not lowercase or space.
module rc4_prga_engine #(
  parameter int ADDR_W  = 8,
  parameter int LEN_MAX = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  rc4_prga_engine_if.master     bus
);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, WAIT_LEN, WR_LEN, RD_SI, CALC_J, RD_SJ, CAP_SJ,
    WR_SJ, WR_SI, RD_F, CAP_F, DONE
  } state_t;

  localparam logic [8:0] LEN_MAX_W = 9'(LEN_MAX);

  state_t            state_r, state_s;
  logic [7:0]        i_r, j_r, si_r, sj_r, len_r;
  logic [ADDR_W-1:0] k_r;
  logic              len_clipped_r, invalid_r;

  logic [7:0]        pt_s;
  logic              last_s, text_bad_s, hdr_over_s;
  logic              wr_en_s, wr_en_dec_s, fin_s;
  logic [7:0]        addr_s_s, data_s_s, data_dec_s;
  logic [ADDR_W-1:0] addr_enc_s, addr_dec_s;

  assign pt_s       = bus.data_from_s_mem ^ bus.data_from_enc_mem;
  assign last_s     = (k_r == ADDR_W'(len_r));
  assign hdr_over_s = ({1'b0, bus.data_from_enc_mem} > LEN_MAX_W);

`ifdef RC4_TEXT_CHECK_EN
  function automatic logic is_text(input logic [7:0] b);
    return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  assign text_bad_s = (state_r == CAP_F) && !is_text(pt_s);
`else
  assign text_bad_s = 1'b0;
`endif

  // Next-state selection; each byte walks the eight states RD_SI..CAP_F.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:     if (bus.start) state_s = RD_LEN; else state_s = IDLE;
      RD_LEN:   state_s = WAIT_LEN;
      WAIT_LEN: state_s = WR_LEN;
      WR_LEN:   if (len_r == 8'd0) state_s = DONE; else state_s = RD_SI;
      RD_SI:    state_s = CALC_J;
      CALC_J:   state_s = RD_SJ;
      RD_SJ:    state_s = CAP_SJ;
      CAP_SJ:   state_s = WR_SJ;
      WR_SJ:    state_s = WR_SI;
      WR_SI:    state_s = RD_F;
      RD_F:     state_s = CAP_F;
      CAP_F:    if (text_bad_s || last_s) state_s = DONE; else state_s = RD_SI;
      DONE:     state_s = IDLE;
      default:  state_s = IDLE;
    endcase
  end

  // Memory strobes, addresses and write data decoded from the current state.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_en_dec_s = 1'b0;
    fin_s       = 1'b0;
    addr_s_s    = 8'd0;
    data_s_s    = 8'd0;
    addr_enc_s  = {ADDR_W{1'b0}};
    addr_dec_s  = {ADDR_W{1'b0}};
    data_dec_s  = 8'd0;
    case (state_r)
      WR_LEN: begin
        wr_en_dec_s = 1'b1;
        data_dec_s  = len_r;
      end
      RD_SI:  addr_s_s = i_r + 8'd1;
      RD_SJ:  addr_s_s = j_r;
      WR_SJ: begin
        wr_en_s  = 1'b1;
        addr_s_s = j_r;
        data_s_s = si_r;
      end
      WR_SI: begin
        wr_en_s  = 1'b1;
        addr_s_s = i_r;
        data_s_s = sj_r;
      end
      RD_F: begin
        addr_s_s   = si_r + sj_r;
        addr_enc_s = k_r;
      end
      CAP_F: begin
        wr_en_dec_s = !text_bad_s;
        addr_dec_s  = k_r;
        data_dec_s  = pt_s;
      end
      DONE:    fin_s = 1'b1;
      default: fin_s = 1'b0;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      i_r           <= 8'd0;
      j_r           <= 8'd0;
      si_r          <= 8'd0;
      sj_r          <= 8'd0;
      len_r         <= 8'd0;
      k_r           <= {ADDR_W{1'b0}};
      len_clipped_r <= 1'b0;
      invalid_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            i_r           <= 8'd0;
            j_r           <= 8'd0;
            len_clipped_r <= 1'b0;
            invalid_r     <= 1'b0;
            k_r           <= ADDR_W'(1);
          end
        end
        WAIT_LEN: begin
          len_r         <= hdr_over_s ? LEN_MAX_W[7:0] : bus.data_from_enc_mem;
          len_clipped_r <= hdr_over_s;
        end
        RD_SI:  i_r <= i_r + 8'd1;
        CALC_J: begin
          si_r <= bus.data_from_s_mem;
          j_r  <= j_r + bus.data_from_s_mem;
        end
        CAP_SJ: sj_r <= bus.data_from_s_mem;
        CAP_F: begin
          // An aborted byte leaves k pointing at the rejected position.
          if (text_bad_s)  invalid_r <= 1'b1;
          else if (!last_s) k_r <= k_r + ADDR_W'(1);
        end
        default: k_r <= k_r;
      endcase
    end
  end

  assign bus.wr_en           = wr_en_s;
  assign bus.wr_en_dec       = wr_en_dec_s;
  assign bus.task_on         = (state_r != IDLE);
  assign bus.fin_strobe      = fin_s;
  assign bus.addr_to_s_mem   = addr_s_s;
  assign bus.data_to_s_mem   = data_s_s;
  assign bus.addr_to_enc_mem = addr_enc_s;
  assign bus.addr_to_dec_mem = addr_dec_s;
  assign bus.data_to_dec_mem = data_dec_s;
  assign bus.len_clipped     = len_clipped_r;
  assign bus.invalid         = invalid_r;

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Directed bench for rc4_prga_engine: s_mem preloaded with KSA("Key"), known ciphertexts decrypted.
// Two engines (LEN_MAX 255 and 4) share one set of behavioural memories through a select.
module tb_rc4_prga_engine;

  localparam int AW = 8;
  localparam logic [79:0] KEY_ENC = 80'h09_BB_F3_16_E8_D9_40_AF_0A_D3;
  localparam logic [79:0] LOW_ENC = 80'h09_9B_F3_16_E8_D9_40_AF_0A_D3;
  localparam logic [79:0] LOW_DEC = 80'h09_70_6C_61_69_6E_74_65_78_74;

  typedef struct {
    string       name;
    bit          sel;
    logic [79:0] enc;
    logic [79:0] dec;
    int          fin;
    bit          lc;
    bit          inv;
    int          swr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic do_load = 1'b0;
  logic do_clr = 1'b0;

  logic [7:0] s_mem [256];
  logic [7:0] s_init [256];
  logic [7:0] enc_mem [256];
  logic [7:0] dec_mem [256];
  logic [7:0] s_rd, enc_rd;

  int n_vec = 0;
  int n_err = 0;
  int fin_cyc, fin_cnt, s_wr_cnt, dec_wr_cnt, rdlen2;
  bit task_ok, lc_f, inv_f;
  vec_t vecs [6];

  always #5 clk = ~clk;

  rc4_prga_engine_if #(.ADDR_W(AW)) b0 ();
  rc4_prga_engine_if #(.ADDR_W(AW)) b1 ();

  rc4_prga_engine #(.ADDR_W(AW), .LEN_MAX(255)) dut0 (.clk(clk), .rst(rst), .bus(b0.master));
  rc4_prga_engine #(.ADDR_W(AW), .LEN_MAX(4))   dut1 (.clk(clk), .rst(rst), .bus(b1.master));

  assign b0.start = start & ~sel;
  assign b1.start = start & sel;
  assign b0.data_from_s_mem = s_rd;
  assign b1.data_from_s_mem = s_rd;
  assign b0.data_from_enc_mem = enc_rd;
  assign b1.data_from_enc_mem = enc_rd;

  logic          m_wr_en, m_wr_en_dec, m_task_on, m_fin, m_lc, m_inv;
  logic [7:0]    m_addr_s, m_data_s, m_data_dec;
  logic [AW-1:0] m_addr_enc, m_addr_dec;
  assign m_wr_en     = sel ? b1.wr_en           : b0.wr_en;
  assign m_wr_en_dec = sel ? b1.wr_en_dec       : b0.wr_en_dec;
  assign m_task_on   = sel ? b1.task_on         : b0.task_on;
  assign m_fin       = sel ? b1.fin_strobe      : b0.fin_strobe;
  assign m_lc        = sel ? b1.len_clipped     : b0.len_clipped;
  assign m_inv       = sel ? b1.invalid         : b0.invalid;
  assign m_addr_s    = sel ? b1.addr_to_s_mem   : b0.addr_to_s_mem;
  assign m_data_s    = sel ? b1.data_to_s_mem   : b0.data_to_s_mem;
  assign m_data_dec  = sel ? b1.data_to_dec_mem : b0.data_to_dec_mem;
  assign m_addr_enc  = sel ? b1.addr_to_enc_mem : b0.addr_to_enc_mem;
  assign m_addr_dec  = sel ? b1.addr_to_dec_mem : b0.addr_to_dec_mem;

  // Synchronous memories with one-cycle read latency.
  always @(posedge clk) begin
    s_rd   <= s_mem[m_addr_s];
    enc_rd <= enc_mem[m_addr_enc];
    if (do_load) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
    end else if (m_wr_en) begin
      s_mem[m_addr_s] <= m_data_s;
    end
    if (do_clr) begin
      for (int a = 0; a < 256; a++) dec_mem[a] <= 8'hEE;
    end else if (m_wr_en_dec) begin
      dec_mem[m_addr_dec] <= m_data_dec;
    end
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic ksa_key();
    logic [7:0] key [3];
    logic [7:0] j, t;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      j = j + s_init[a] + key[a % 3];
      t = s_init[a]; s_init[a] = s_init[j]; s_init[j] = t;
    end
  endtask

  // Fresh s_mem, ciphertext loaded, dec_mem filled with 0xEE so unwritten bytes stay visible.
  task automatic load(input logic [79:0] enc);
    logic [79:0] e;
    ksa_key();
    e = enc;
    for (int n = 0; n < 10; n++) enc_mem[n] = e[79-8*n -: 8];
    do_load = 1'b1; do_clr = 1'b1;
    @(negedge clk);
    do_load = 1'b0; do_clr = 1'b0;
  endtask

  function automatic logic [79:0] dec_word();
    logic [79:0] w;
    for (int n = 0; n < 10; n++) w[79-8*n -: 8] = dec_mem[n];
    return w;
  endfunction

  // Called at a negedge; start is sampled by the next posedge (cycle 0).
  task automatic run_msg(input bit s, input int hold, input int budget, input int rst_at);
    sel = s; start = 1'b1;
    fin_cyc = -1; fin_cnt = 0; s_wr_cnt = 0; dec_wr_cnt = 0; rdlen2 = -1;
    task_ok = 1'b1; lc_f = 1'b0; inv_f = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c >= hold) start = 1'b0;
      if (rst_at > 0 && c == rst_at + 1) begin
        chk("reset_mid_outputs",
            80'({m_task_on, m_wr_en, m_wr_en_dec, m_fin, m_addr_s, m_data_s,
                 m_addr_enc, m_addr_dec, m_data_dec, m_lc, m_inv}), 80'd0);
        rst = 1'b0;
        break;
      end
      if (rst_at > 0 && c == rst_at) rst = 1'b1;
      if (m_fin) fin_cnt++;
      if (fin_cyc < 0) begin
        if (!m_task_on) task_ok = 1'b0;
        if (m_wr_en) s_wr_cnt++;
        if (m_wr_en_dec) dec_wr_cnt++;
        if (m_fin) begin fin_cyc = c; lc_f = m_lc; inv_f = m_inv; end
      end else if (c == fin_cyc + 1) begin
        if (m_task_on) task_ok = 1'b0;
        if (hold <= 1) break;
      end else if (m_task_on && rdlen2 < 0) begin
        rdlen2 = c;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    load(v.enc);
    run_msg(v.sel, 1, 400, 0);
    chk({v.name, "_fin_cycle"}, 80'(fin_cyc), 80'(v.fin));
    chk({v.name, "_fin_count"}, 80'(fin_cnt), 80'd1);
    chk({v.name, "_task_on_window"}, 80'(task_ok), 80'd1);
    chk({v.name, "_s_writes"}, 80'(s_wr_cnt), 80'(v.swr));
    chk({v.name, "_len_clipped"}, 80'(lc_f), 80'(v.lc));
    chk({v.name, "_invalid"}, 80'(inv_f), 80'(v.inv));
    chk({v.name, "_dec"}, dec_word(), v.dec);
  endtask

  function automatic vec_t mk(input string nm, input bit s, input logic [79:0] e, input logic [79:0] d,
                              input int f, input bit lc, input bit inv, input int swr);
    vec_t v;
    v.name = nm; v.sel = s; v.enc = e; v.dec = d; v.fin = f; v.lc = lc; v.inv = inv; v.swr = swr;
    return v;
  endfunction

  initial begin
`ifdef RC4_TEXT_CHECK_EN
    vecs[0] = mk("key",   1'b0, KEY_ENC, 80'h09_EE_EE_EE_EE_EE_EE_EE_EE_EE, 12, 1'b0, 1'b1, 2);
    vecs[3] = mk("clip",  1'b1, KEY_ENC, 80'h04_EE_EE_EE_EE_EE_EE_EE_EE_EE, 12, 1'b1, 1'b1, 2);
`else
    vecs[0] = mk("key",   1'b0, KEY_ENC, 80'h09_50_6C_61_69_6E_74_65_78_74, 76, 1'b0, 1'b0, 18);
    vecs[3] = mk("clip",  1'b1, KEY_ENC, 80'h04_50_6C_61_69_EE_EE_EE_EE_EE, 36, 1'b1, 1'b0, 8);
`endif
    vecs[1] = mk("lower",  1'b0, LOW_ENC, LOW_DEC, 76, 1'b0, 1'b0, 18);
    vecs[2] = mk("zero",   1'b0, 80'h00_BB_F3_16_E8_D9_40_AF_0A_D3,
                 80'h00_EE_EE_EE_EE_EE_EE_EE_EE_EE, 4, 1'b0, 1'b0, 0);
    vecs[4] = mk("clip_lo", 1'b1, LOW_ENC, 80'h04_70_6C_61_69_EE_EE_EE_EE_EE, 36, 1'b1, 1'b0, 8);
    vecs[5] = mk("exact4", 1'b1, 80'h04_9B_F3_16_E8_D9_40_AF_0A_D3,
                 80'h04_70_6C_61_69_EE_EE_EE_EE_EE, 36, 1'b0, 1'b0, 8);

    repeat (3) @(negedge clk);
    chk("reset_outputs_dut0",
        80'({b0.task_on, b0.wr_en, b0.wr_en_dec, b0.fin_strobe, b0.addr_to_s_mem, b0.data_to_s_mem,
             b0.addr_to_enc_mem, b0.addr_to_dec_mem, b0.data_to_dec_mem, b0.len_clipped, b0.invalid}), 80'd0);
    chk("reset_outputs_dut1",
        80'({b1.task_on, b1.wr_en, b1.wr_en_dec, b1.fin_strobe, b1.addr_to_s_mem, b1.data_to_s_mem,
             b1.addr_to_enc_mem, b1.addr_to_dec_mem, b1.data_to_dec_mem, b1.len_clipped, b1.invalid}), 80'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Reset in cycle 20 of a full-length run, then a clean rerun from a fresh s_mem.
    load(LOW_ENC);
    run_msg(1'b0, 1, 100, 20);
    @(negedge clk);
    run_vec(vecs[1]);

    // start held high: first run ends in cycle 20, the retrigger's RD_LEN lands in cycle 22.
    load(80'h02_9B_F3_16_E8_D9_40_AF_0A_D3);
    run_msg(1'b0, 200, 200, 0);
    chk("hold_fin_cycle", 80'(fin_cyc), 80'd20);
    chk("hold_rdlen2_cycle", 80'(rdlen2), 80'd22);
    chk("hold_first_dec_writes", 80'(dec_wr_cnt), 80'd3);
    chk("hold_first_s_writes", 80'(s_wr_cnt), 80'd4);
    chk("hold_task_on_window", 80'(task_ok), 80'd1);
    begin
      int n;
      n = 0;
      while (m_task_on && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("hold_returns_idle", 80'(m_task_on), 80'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
